// File: rtl/cdc_hs_tx.sv
// Transmit end of a 4-phase req/ack clock-domain-crossing handshake.
// A word accepted over valid/ready is held on req_data. The block raises req,
// waits for the synchronised ack, drops req, and waits for ack to fall again.
// A sticky timeout flag reports a far end that is slow to respond. The flag
// does not abort the handshake.
module cdc_hs_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  req,
    output logic [DATA_WIDTH-1:0] req_data,
    input  logic                  ack_async,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    // The counter must be able to hold TIMEOUT_CYCLES itself.
    // A width of 1 keeps the disabled case legal.
    localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic                    tx_done_q, tx_done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    ack_meta_q, ack_sync_q;
    logic                    cnt_reach;

    // Two-flop synchroniser bringing the far-domain ack into clk.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_async;
            ack_sync_q <= ack_meta_q;
        end
    end

    // A stale high ack from the previous transfer must clear before a new word is taken.
    assign tx_ready    = (state_q == IDLE) && !ack_sync_q;
    assign busy        = (state_q != IDLE);
    assign req         = req_q;
    assign req_data    = req_data_q;
    assign tx_done     = tx_done_q;
    assign timeout_err = timeout_err_q;

    // Handshake sequencing: capture, raise req, drop req on ack, finish on ack low.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        req_data_d = req_data_q;
        tx_done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    req_data_d = tx_data;
                    req_d      = 1'b1;
                    state_d    = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_sync_q) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_sync_q) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Wait-time counter. The flag sets only on the edge where the count first
    // reaches the limit, so clearing it while the counter sits saturated works.
    always_comb begin
        cnt_d         = cnt_q;
        cnt_reach     = 1'b0;
        timeout_err_d = timeout_err_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
            cnt_d     = cnt_q + 1'b1;
            cnt_reach = (cnt_d == CNT_MAX);
        end
        if (err_clr) begin
            timeout_err_d = 1'b0;
        end
        if (cnt_reach) begin
            timeout_err_d = 1'b1;
        end
        if (TIMEOUT_CYCLES == 0) begin
            cnt_d         = '0;
            timeout_err_d = 1'b0;
        end
    end

    // State, output and counter registers. Reset drops req immediately.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            req_data_q    <= '0;
            tx_done_q     <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            req_data_q    <= req_data_d;
            tx_done_q     <= tx_done_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: directed handshake timing, a randomised far-end responder,
// and a word-level scoreboard of captured versus offered data.
module tb_cdc_hs_tx;

    logic       clk;
    logic       n_reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       req;
    logic [7:0] req_data;
    logic       ack_async;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    logic       man_ack   = 1'b0;
    logic       auto_ack  = 1'b0;
    logic       resp_ack  = 1'b0;
    int         resp_wait = 0;
    int         max_delay = 0;

    int         checks = 0;
    int         errors = 0;
    int         exp_done = 0;
    int         done_cnt = 0;
    int         data_viol = 0;
    bit         mon_en = 1'b0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    assign ack_async = auto_ack ? resp_ack : man_ack;

    cdc_hs_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .req         (req),
        .req_data    (req_data),
        .ack_async   (ack_async),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Far end: mirrors req on ack after a random number of cycles.
    always @(posedge clk) begin
        #2;
        if (auto_ack && (resp_ack !== req)) begin
            if (resp_wait > 0) begin
                resp_wait--;
            end else begin
                resp_ack  = req;
                resp_wait = $urandom_range(0, max_delay);
            end
        end
    end

    // Protocol monitor: word seen at each req rise, done pulses, and any
    // req_data change that is not the capture edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (req && !prev_req) obs_q.push_back(req_data);
            else if (req_data !== prev_data) data_viol++;
            if (tx_done) done_cnt++;
        end
        prev_req  = req;
        prev_data = req_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a word and hold it until accepted; returns just after the capture edge.
    task automatic send(input logic [7:0] w);
        bit accepted;
        accepted = 1'b0;
        tx_valid = 1'b1;
        tx_data  = w;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (tx_ready) begin
                exp_q.push_back(w);
                exp_done++;
                accepted = 1'b1;
            end
            step(1);
        end
        check("send_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && done_cnt != exp_done; i++) step(1);
        check("done_count", done_cnt, exp_done);
    endtask

    task automatic scoreboard();
        check("sb_size", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check("sb_word", (i < obs_q.size()) ? {24'd0, obs_q[i]} : 32'hxxxx_xxxx, {24'd0, exp_q[i]});
        end
        check("data_stable", data_viol, 0);
    endtask

    initial begin
        n_reset  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        err_clr  = 1'b0;

        // Reset state
        step(2);
        check("rst_req", req, 1'b0);
        check("rst_req_data", req_data, 8'h00);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        n_reset = 1'b1;
        step(1);
        mon_en = 1'b1;

        // Single word 0xA5, manual ack one cycle after req
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        check("t1_ready_before", tx_ready, 1'b1);
        step(1);
        tx_valid = 1'b0;
        exp_q.push_back(8'hA5);
        exp_done++;
        check("t1_req_rise", req, 1'b1);
        check("t1_req_data", req_data, 8'hA5);
        check("t1_busy", busy, 1'b1);
        check("t1_ready_busy", tx_ready, 1'b0);
        step(1);
        man_ack = 1'b1;
        step(2);
        check("t1_req_hold", req, 1'b1);
        step(1);
        check("t1_req_fall", req, 1'b0);
        check("t1_busy_lo", busy, 1'b1);
        man_ack = 1'b0;
        step(2);
        check("t1_done_early", tx_done, 1'b0);
        step(1);
        check("t1_done_pulse", tx_done, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_ready_after", tx_ready, 1'b1);
        step(1);
        check("t1_done_once", tx_done, 1'b0);
        check("t1_done_count", done_cnt, 1);

        // Stale high ack in IDLE blocks new requests
        man_ack = 1'b1;
        step(1);
        check("t6_ready_1edge", tx_ready, 1'b1);
        step(1);
        check("t6_ready_blocked", tx_ready, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t6_no_busy", busy, 1'b0);
            check("t6_no_req", req, 1'b0);
        end
        tx_valid = 1'b0;
        man_ack  = 1'b0;
        step(1);
        check("t6_ready_still_low", tx_ready, 1'b0);
        step(1);
        check("t6_ready_back", tx_ready, 1'b1);

        // Back-to-back words with tx_valid held, immediate responder
        max_delay = 0;
        auto_ack  = 1'b1;
        send(8'h11);
        send(8'h22);
        tx_valid = 1'b0;
        wait_done();
        scoreboard();

        // Data changes while busy must not be captured
        max_delay = 3;
        send(8'h3C);
        begin
            bit finished;
            finished = 1'b0;
            for (int i = 0; i < 100 && !finished; i++) begin
                if (tx_done) begin
                    tx_valid = 1'b0;
                    finished = 1'b1;
                end else begin
                    check("t3_req_data_hold", req_data, 8'h3C);
                    tx_data = 8'($urandom);
                    step(1);
                end
            end
            check("t3_finished", {31'd0, finished}, 32'd1);
        end
        wait_done();
        scoreboard();

        // Random burst with random gaps and responder delays
        for (int n = 0; n < 20; n++) begin
            tx_valid = 1'b0;
            step($urandom_range(0, 2));
            send(8'($urandom));
        end
        tx_valid = 1'b0;
        wait_done();
        scoreboard();
        check("t7_no_timeout", timeout_err, 1'b0);

        // Timeout with no ack, late completion, set-beats-clear, clear
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        send(8'h5A);
        tx_valid = 1'b0;
        step(7);
        check("t4_err_before", timeout_err, 1'b0);
        check("t4_req_wait", req, 1'b1);
        step(1);
        check("t4_err_set", timeout_err, 1'b1);
        check("t4_req_stays", req, 1'b1);
        step(4);
        check("t4_err_sticky", timeout_err, 1'b1);
        check("t4_busy", busy, 1'b1);
        man_ack = 1'b1;
        step(2);
        check("t4_req_hold", req, 1'b1);
        step(1);
        check("t4_req_fall", req, 1'b0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("t4_err_clr", timeout_err, 1'b0);
        step(6);
        check("t4_lo_before", timeout_err, 1'b0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("t4_set_wins", timeout_err, 1'b1);
        man_ack = 1'b0;
        step(2);
        check("t4_done_early", tx_done, 1'b0);
        step(1);
        check("t4_done", tx_done, 1'b1);
        check("t4_err_kept", timeout_err, 1'b1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("t4_err_cleared", timeout_err, 1'b0);
        check("t4_done_count", done_cnt, exp_done);

        // Asynchronous reset in REQ_HI
        send(8'($urandom));
        tx_valid = 1'b0;
        step(9);
        check("t5_req_before", req, 1'b1);
        check("t5_err_before", timeout_err, 1'b1);
        mon_en  = 1'b0;
        n_reset = 1'b0;
        #1;
        check("t5_req_async", req, 1'b0);
        check("t5_busy_async", busy, 1'b0);
        check("t5_done_async", tx_done, 1'b0);
        check("t5_data_async", req_data, 8'h00);
        check("t5_err_async", timeout_err, 1'b0);
        step(1);
        n_reset = 1'b1;
        check("t5_ready_release", tx_ready, 1'b1);
        step(2);
        check("t5_idle_after", busy, 1'b0);
        check("t5_req_after", req, 1'b0);
        mon_en = 1'b1;
        // The aborted word was captured and raised req but never completes.
        exp_done--;
        check("t5_done_count", done_cnt, exp_done);
        scoreboard();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
